spi_slave_ctrl: RTL and testbench
=================================

Name: spi_slave_ctrl

Overview:
- Frame-level controller between an external SPI master and the 4x8-bit SPI slave register file.
- Oversamples SCLK/MOSI/SS in the system clock domain and decodes command/data bytes.
- Sequences register-file writes and reads, including burst access with address auto-increment, and drives MISO for reads.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the SCLK/MOSI/SS synchronizers (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK frequency.
- reset_n  input  1  asynchronous, active-low reset.
- SCLK  input  1  SPI serial clock, asynchronous to clk.
- MOSI  input  1  SPI master-out data.
- SS  input  1  SPI slave select, active low.
- MISO  output  1  SPI master-in data.
- reg_write  output  1  one-cycle register-file write strobe.
- reg_addr  output  2  register-file address.
- reg_wdata  output  8  register-file write data.
- reg_rdata  input  8  register-file read data; combinational from reg_addr.
- done  output  1  one-cycle pulse per completed data byte, read or write.
- busy  output  1  high while a frame is active (synchronized SS low).
- frame_err  output  1  one-cycle pulse when SS deasserts mid-byte.

Behaviour:
- Reset values: MISO=0, reg_write=0, reg_addr=0, reg_wdata=0, done=0, busy=0, frame_err=0. The FSM returns to IDLE and all counters and shift registers clear. Reset is asynchronous and may occur mid-frame; no write is issued afterwards.
- Synchronization: SCLK, MOSI and SS each pass through SYNC_STAGES flip-flops. Edge detect compares the last synchronized stage against a delay register. "rise"/"fall" are one-clk pulses.
- bit_cnt (3 bits) increments on each rise, MOSI is sampled into rx_sh on each rise, and bit_cnt wraps 7->0. A byte is complete on the rise that wraps bit_cnt to 0. Byte-complete actions take effect on the next clk.
- Command byte format: bit7 = R/nW (1 = read); bits6:2 ignored; bits1:0 = start address.
- FSM states:
  - IDLE: SS high; busy=0. Synchronized SS falling -> CMD, clearing bit_cnt and rx_sh.
  - CMD: on byte complete, latch reg_addr = cmd[1:0]. Go to WR if R/nW=0. Go to RD if R/nW=1; in that case load tx_sh = reg_rdata one clk after reg_addr updates.
  - WR: on byte complete, pulse reg_write and done for one clk, with reg_wdata = received byte and reg_addr = current address. On the following clk, reg_addr increments and wraps 3->0. Stay in WR (burst).
  - RD: MISO = tx_sh[7]. On fall with bit_cnt != 0, tx_sh shifts left (the falling edge that ends a byte does not shift). On byte complete, pulse done, increment reg_addr (wrapping 3->0), then reload tx_sh from reg_rdata on the next clk. Stay in RD.
- SS rising (synchronized), from any non-IDLE state, returns the FSM to IDLE in the same clk:
  - If bit_cnt != 0, pulse frame_err and discard the partial byte (no reg_write, no done).
  - If the command byte is incomplete, pulse frame_err when bit_cnt != 0; a frame of exactly 0 bits gives no error.
- SS low with no SCLK: FSM holds state indefinitely.
- MISO is 0 whenever the FSM is not in RD; no tristate.
- reg_write and SS rise in the same clk: the write completes and the FSM then goes to IDLE.
- Latency: reg_write asserts SYNC_STAGES+2 clk after the SCLK rising edge that carries the last data bit.

Test Plan:
- Write: SS low, send 0x02 then 0xA5, SS high -> one reg_write pulse with reg_addr=2, reg_wdata=0xA5; one done pulse; frame_err=0; busy low after SS rises.
- Read: file holds reg1=0x3C; send 0x81 then 8 dummy clocks -> MISO presents 0,0,1,1,1,1,0,0 on successive rising edges; one done pulse; no reg_write.
- Burst write with wrap: cmd 0x03 followed by 0x11, 0x22, 0x33 -> writes addr3=0x11, addr0=0x22, addr1=0x33; three done pulses.
- Burst read: regs {0x10, 0x20, 0x30, 0x40}; cmd 0x82 + 24 clocks -> MISO bytes 0x30, 0x40, 0x10.
- Abort: cmd 0x01, 4 data bits, SS high -> frame_err pulses once; no reg_write; FSM in IDLE; next full frame 0x01/0x5A writes reg1=0x5A.
- Reset mid-frame: assert reset_n=0 after 5 data bits of a write -> all outputs 0 immediately; after release with SS high, no reg_write occurs.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave frame controller. Oversamples the SPI pins in the clk
// domain, decodes a command byte (R/nW + start address), then streams data
// bytes into or out of a 4x8 register file with address auto-increment.
module spi_slave_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       SCLK,
   input  logic       MOSI,
   input  logic       SS,
   output logic       MISO,
   output logic       reg_write,
   output logic [1:0] reg_addr,
   output logic [7:0] reg_wdata,
   input  logic [7:0] reg_rdata,
   output logic       done,
   output logic       busy,
   output logic       frame_err
);

   // state | meaning
   // IDLE  | no frame, SS high
   // CMD   | receiving the command byte
   // WR    | receiving write data bytes (burst)
   // RD    | shifting read data out on MISO (burst)
   typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
   logic sclk_s, mosi_s, ss_s;
   logic sclk_d, ss_d;
   logic sclk_rise, sclk_fall, ss_rise, ss_fall;

   logic [2:0] bit_cnt;
   logic [7:0] rx_sh;
   logic [7:0] tx_sh;
   logic       byte_cmp;
   logic       load_pend;

   logic wr_go, done_go, err_go, addr_load, rd_adv, load_go;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ss_rise   = ss_s & ~ss_d;
   assign ss_fall   = ~ss_s & ss_d;

   assign busy = (state != IDLE);
   assign MISO = (state == RD) ? tx_sh[7] : 1'b0;

   // Pin synchronizers and edge-detect delay registers. SS resets high so a
   // released reset never looks like the start of a frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_sync   <= '1;
         sclk_d    <= 1'b0;
         ss_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
         sclk_d    <= sclk_s;
         ss_d      <= ss_s;
      end
   end

   // Bit counter and receive shifter; byte_cmp flags a full byte one clk later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt  <= 3'd0;
         rx_sh    <= 8'h00;
         byte_cmp <= 1'b0;
      end else begin
         byte_cmp <= 1'b0;
         if ((state == IDLE && ss_fall) || (state != IDLE && ss_rise)) begin
            bit_cnt <= 3'd0;
            rx_sh   <= 8'h00;
         end else if (state != IDLE && sclk_rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_sh    <= {rx_sh[6:0], mosi_s};
            byte_cmp <= (bit_cnt == 3'd7);
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state and per-byte action decode. SS rising overrides the state
   // move but a write decoded in the same clk still goes out.
   always_comb begin
      state_nxt = state;
      wr_go     = 1'b0;
      done_go   = 1'b0;
      err_go    = 1'b0;
      addr_load = 1'b0;
      rd_adv    = 1'b0;
      load_go   = 1'b0;
      case (state)
         IDLE: if (ss_fall) state_nxt = CMD;
         CMD: begin
            if (byte_cmp) begin
               addr_load = 1'b1;
               if (rx_sh[7]) begin
                  state_nxt = RD;
                  load_go   = 1'b1;
               end else begin
                  state_nxt = WR;
               end
            end
         end
         WR: begin
            if (byte_cmp) begin
               wr_go   = 1'b1;
               done_go = 1'b1;
            end
         end
         RD: begin
            if (byte_cmp) begin
               done_go = 1'b1;
               rd_adv  = 1'b1;
               load_go = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE && ss_rise) begin
         state_nxt = IDLE;
         if (bit_cnt != 3'd0) err_go = 1'b1;
      end
   end

   // Register-file interface and status strobes. The address advances the
   // clk after a write strobe, or together with done on a read byte.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_write <= 1'b0;
         reg_wdata <= 8'h00;
         reg_addr  <= 2'd0;
         done      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         reg_write <= wr_go;
         done      <= done_go;
         frame_err <= err_go;
         if (wr_go) reg_wdata <= rx_sh;
         if (addr_load)
            reg_addr <= rx_sh[1:0];
         else if (rd_adv || reg_write)
            reg_addr <= reg_addr + 2'd1;
      end
   end

   // Transmit shifter: reload one clk after the address settles, shift on
   // falling SCLK except the fall that closes a byte.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_sh     <= 8'h00;
         load_pend <= 1'b0;
      end else begin
         load_pend <= load_go;
         if (load_pend)
            tx_sh <= reg_rdata;
         else if (state == RD && sclk_fall && bit_cnt != 3'd0)
            tx_sh <= {tx_sh[6:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
module tb_spi_slave_ctrl;

   localparam int HALF = 8;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       SCLK, MOSI, SS;
   logic       MISO, reg_write, done, busy, frame_err;
   logic [1:0] reg_addr;
   logic [7:0] reg_wdata, reg_rdata;

   logic [7:0] regs [4];
   logic [9:0] wr_exp [$];
   logic [9:0] wr_obs [$];
   logic [7:0] rd_exp [$];
   logic [7:0] rd_obs [$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rise_cyc = 0;
   int wr_cyc = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   spi_slave_ctrl #(.SYNC_STAGES(SYNC)) dut (
      .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .MOSI(MOSI), .SS(SS),
      .MISO(MISO), .reg_write(reg_write), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .done(done),
      .busy(busy), .frame_err(frame_err)
   );

   // register file attached to the controller
   assign reg_rdata = regs[reg_addr];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset_n && reg_write) regs[reg_addr] <= reg_wdata;
   end

   // output monitor: collect writes and count strobes away from the active edge
   always @(negedge clk) begin
      if (reset_n) begin
         if (reg_write) begin
            wr_obs.push_back({reg_addr, reg_wdata});
            wr_cnt++;
            wr_cyc = cyc;
         end
         if (done) done_cnt++;
         if (frame_err) err_cnt++;
      end
   end

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         MOSI = tx[i];
         repeat (HALF) @(negedge clk);
         SCLK = 1'b1;
         rx[i] = MISO;
         rise_cyc = cyc;
         repeat (HALF) @(negedge clk);
         SCLK = 1'b0;
      end
   endtask

   task automatic ss_low();
      SS = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic ss_high();
      repeat (6) @(negedge clk);
      SS = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [14:0] outs;
      reset_n = 1'b0; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      for (int i = 0; i < 4; i++) regs[i] = 8'h00;
      repeat (3) @(negedge clk);
      outs = {MISO, reg_write, reg_addr, reg_wdata, done, busy, frame_err};
      total++;
      if (outs !== 15'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", outs);
      end
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_busy got=%b want=0", busy);
      end
   endtask

   task automatic test_write();
      logic [7:0] rx;
      logic [9:0] e, o;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      ss_low();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL write_busy got=%b want=1", busy);
      end
      spi_bits(8'h02, 8, rx);
      wr_exp.push_back({2'd2, 8'hA5});
      spi_bits(8'hA5, 8, rx);
      total++;
      if (wr_cyc - rise_cyc !== SYNC + 2) begin
         bad++;
         $display("FAIL write_latency got=%0d want=%0d", wr_cyc - rise_cyc, SYNC + 2);
      end
      ss_high();
      while (wr_exp.size() > 0) begin
         e = wr_exp.pop_front();
         o = (wr_obs.size() > 0) ? wr_obs.pop_front() : 10'h3FF;
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL write_data got=%h want=%h", o, e);
         end
      end
      total++;
      if (wr_obs.size() != 0 || done_cnt - d0 != 1 || err_cnt != e0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL write_status extra=%0d done=%0d err=%0d busy=%b want 0/1/0/0",
                  wr_obs.size(), done_cnt - d0, err_cnt - e0, busy);
      end
      wr_obs.delete();
   endtask

   task automatic test_read();
      logic [7:0] rx, e;
      int d0, w0;
      regs[1] = 8'h3C;
      d0 = done_cnt; w0 = wr_cnt;
      ss_low();
      spi_bits(8'h81, 8, rx);
      rd_exp.push_back(8'h3C);
      spi_bits(8'h00, 8, rx);
      rd_obs.push_back(rx);
      ss_high();
      while (rd_exp.size() > 0) begin
         e = rd_exp.pop_front();
         rx = (rd_obs.size() > 0) ? rd_obs.pop_front() : 8'hxx;
         total++;
         if (rx !== e) begin
            bad++;
            $display("FAIL read_miso_bits got=%h want=%h", rx, e);
         end
      end
      total++;
      if (done_cnt - d0 != 1 || wr_cnt != w0 || MISO !== 1'b0) begin
         bad++;
         $display("FAIL read_status done=%0d writes=%0d miso=%b want 1/0/0",
                  done_cnt - d0, wr_cnt - w0, MISO);
      end
   endtask

   task automatic test_burst_write();
      logic [7:0] rx;
      logic [9:0] e, o;
      logic [7:0] data [3];
      int d0;
      data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
      d0 = done_cnt;
      ss_low();
      spi_bits(8'h03, 8, rx);
      for (int i = 0; i < 3; i++) begin
         wr_exp.push_back({2'(3 + i), data[i]});
         spi_bits(data[i], 8, rx);
      end
      ss_high();
      while (wr_exp.size() > 0) begin
         e = wr_exp.pop_front();
         o = (wr_obs.size() > 0) ? wr_obs.pop_front() : 10'h3FF;
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL burst_write got=%h want=%h", o, e);
         end
      end
      total++;
      if (done_cnt - d0 != 3 || wr_obs.size() != 0) begin
         bad++;
         $display("FAIL burst_write_done got=%0d extra=%0d want 3/0", done_cnt - d0, wr_obs.size());
      end
      wr_obs.delete();
   endtask

   task automatic test_burst_read();
      logic [7:0] rx, e;
      int d0;
      regs[0] = 8'h10; regs[1] = 8'h20; regs[2] = 8'h30; regs[3] = 8'h40;
      d0 = done_cnt;
      ss_low();
      spi_bits(8'h82, 8, rx);
      for (int i = 0; i < 3; i++) begin
         rd_exp.push_back(8'h10 * 8'((2 + i) % 4 + 1));
         spi_bits(8'hFF, 8, rx);
         rd_obs.push_back(rx);
      end
      ss_high();
      while (rd_exp.size() > 0) begin
         e = rd_exp.pop_front();
         rx = (rd_obs.size() > 0) ? rd_obs.pop_front() : 8'hxx;
         total++;
         if (rx !== e) begin
            bad++;
            $display("FAIL burst_read got=%h want=%h", rx, e);
         end
      end
      total++;
      if (done_cnt - d0 != 3) begin
         bad++;
         $display("FAIL burst_read_done got=%0d want=3", done_cnt - d0);
      end
   endtask

   task automatic test_abort();
      logic [7:0] rx;
      logic [9:0] e, o;
      int e0, w0, d0;
      e0 = err_cnt; w0 = wr_cnt; d0 = done_cnt;
      ss_low();
      spi_bits(8'h01, 8, rx);
      spi_bits(8'hF0, 4, rx);
      ss_high();
      total++;
      if (err_cnt - e0 != 1 || wr_cnt != w0 || done_cnt != d0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort err=%0d writes=%0d done=%0d busy=%b want 1/0/0/0",
                  err_cnt - e0, wr_cnt - w0, done_cnt - d0, busy);
      end
      ss_low();
      spi_bits(8'h01, 8, rx);
      wr_exp.push_back({2'd1, 8'h5A});
      spi_bits(8'h5A, 8, rx);
      ss_high();
      while (wr_exp.size() > 0) begin
         e = wr_exp.pop_front();
         o = (wr_obs.size() > 0) ? wr_obs.pop_front() : 10'h3FF;
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL abort_recover got=%h want=%h", o, e);
         end
      end
      total++;
      if (regs[1] !== 8'h5A || err_cnt - e0 != 1) begin
         bad++;
         $display("FAIL abort_regfile got=%h err=%0d want 5a/1", regs[1], err_cnt - e0);
      end
      wr_obs.delete();
   endtask

   task automatic test_empty_frame();
      int e0, d0;
      e0 = err_cnt; d0 = done_cnt;
      ss_low();
      repeat (40) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL idle_sclk_hold busy=%b want=1", busy);
      end
      ss_high();
      total++;
      if (err_cnt != e0 || done_cnt != d0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL empty_frame err=%0d done=%0d busy=%b want 0/0/0",
                  err_cnt - e0, done_cnt - d0, busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] rx;
      logic [14:0] outs;
      int w0, e0;
      w0 = wr_cnt; e0 = err_cnt;
      ss_low();
      spi_bits(8'h00, 8, rx);
      spi_bits(8'hFF, 5, rx);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      outs = {MISO, reg_write, reg_addr, reg_wdata, done, busy, frame_err};
      total++;
      if (outs !== 15'h0) begin
         bad++;
         $display("FAIL reset_mid_frame_outputs got=%h want=0", outs);
      end
      SS = 1'b1;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      total++;
      if (wr_cnt != w0 || err_cnt != e0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_frame_after writes=%0d err=%0d busy=%b want 0/0/0",
                  wr_cnt - w0, err_cnt - e0, busy);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_burst_write();
      test_burst_read();
      test_abort();
      test_empty_frame();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
